// File: rtl/regfile_wb_if.sv
// Bus bundle for regfile_wb_arbiter: producer handshakes, decode reservations,
// the register-file write port and the pending-write scoreboard.
interface regfile_wb_if #(
   parameter int WIDTH = 32
) ();
   localparam int AW = $clog2(WIDTH);

   logic             issue_valid;
   logic [AW-1:0]    issue_addr;
   logic             alu_valid;
   logic             alu_ready;
   logic [AW-1:0]    alu_addr;
   logic [WIDTH-1:0] alu_data;
   logic             lsu_valid;
   logic             lsu_ready;
   logic [AW-1:0]    lsu_addr;
   logic [WIDTH-1:0] lsu_data;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] pending;

   // master: producers and decode; slave: the arbiter.
   modport master (
      output issue_valid, issue_addr,
      output alu_valid, alu_addr, alu_data,
      output lsu_valid, lsu_addr, lsu_data,
      input  alu_ready, lsu_ready,
      input  wr_en, wr_addr, wr_data, pending
   );

   modport slave (
      input  issue_valid, issue_addr,
      input  alu_valid, alu_addr, alu_data,
      input  lsu_valid, lsu_addr, lsu_data,
      output alu_ready, lsu_ready,
      output wr_en, wr_addr, wr_data, pending
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin merge of ALU/LSU writeback onto one register-file write port with
// pending-write scoreboard. Define REGFILE_WB_BYPASS_EN for the empty-FIFO bypass path.

// Reservation rules watched alongside the arbiter.
module regfile_wb_arbiter_chk #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
) (
   input logic             clk,
   input logic             rst,
   input logic             issue_valid,
   input logic [AW-1:0]    issue_addr,
   input logic             wr_en,
   input logic [AW-1:0]    wr_addr,
   input logic [WIDTH-1:0] pending
);
   // A register may be re-reserved only on the edge its earlier write retires.
   property p_no_double_reserve;
      @(posedge clk) disable iff (!rst)
         (issue_valid && (issue_addr != {AW{1'b0}}) && pending[issue_addr])
            |-> (wr_en && (wr_addr == issue_addr));
   endproperty
   a_no_double_reserve: assert property (p_no_double_reserve);

   a_x0_never_pending: assert property (@(posedge clk) pending[0] == 1'b0);
endmodule

module regfile_wb_arbiter #(
   parameter int WIDTH      = 32,
   parameter int FIFO_DEPTH = 2
) (
   input logic         clk,
   input logic         rst,
   regfile_wb_if.slave bus
);
   localparam int AW = $clog2(WIDTH);
   localparam int FW = $clog2(FIFO_DEPTH);

   typedef enum logic {RR_ALU = 1'b0, RR_LSU = 1'b1} rr_t;

   rr_t              rr_r;
   rr_t              rr_next_s;
   logic [AW-1:0]    q_addr_r [2][FIFO_DEPTH];
   logic [WIDTH-1:0] q_data_r [2][FIFO_DEPTH];
   logic [FW:0]      wptr_r [2];
   logic [FW:0]      rptr_r [2];
   logic [1:0]       in_valid_s;
   logic [AW-1:0]    in_addr_s [2];
   logic [WIDTH-1:0] in_data_s [2];
   logic [1:0]       empty_s;
   logic [1:0]       full_s;
   logic [1:0]       accept_s;
   logic [1:0]       push_s;
   logic [1:0]       pop_s;
   logic [1:0]       byp_s;
   logic             sel_valid_s;
   logic [AW-1:0]    sel_addr_s;
   logic [WIDTH-1:0] sel_data_s;
   logic [WIDTH-1:0] pending_next_s;
   logic             wr_en_r;
   logic [AW-1:0]    wr_addr_r;
   logic [WIDTH-1:0] wr_data_r;
   logic [WIDTH-1:0] pending_r;

   // Producer 0 is the ALU, producer 1 the LSU; occupancy from wrap-bit pointers.
   always_comb begin
      in_valid_s   = {bus.lsu_valid, bus.alu_valid};
      in_addr_s[0] = bus.alu_addr;
      in_addr_s[1] = bus.lsu_addr;
      in_data_s[0] = bus.alu_data;
      in_data_s[1] = bus.lsu_data;
      for (int i = 0; i < 2; i++) begin
         empty_s[i]  = (wptr_r[i] == rptr_r[i]);
         full_s[i]   = (wptr_r[i][FW] != rptr_r[i][FW]) &&
                       (wptr_r[i][FW-1:0] == rptr_r[i][FW-1:0]);
         accept_s[i] = in_valid_s[i] && !full_s[i];
      end
   end

   assign bus.alu_ready = !full_s[0];
   assign bus.lsu_ready = !full_s[1];

   // Arbitration: one head per cycle; the pointer flips only when both compete.
   always_comb begin
      rr_next_s   = rr_r;
      pop_s       = 2'b00;
      byp_s       = 2'b00;
      sel_valid_s = 1'b0;
      sel_addr_s  = {AW{1'b0}};
      sel_data_s  = {WIDTH{1'b0}};
      if (!empty_s[0] && !empty_s[1]) begin
         if (rr_r == RR_ALU) begin
            pop_s     = 2'b01;
            rr_next_s = RR_LSU;
         end else begin
            pop_s     = 2'b10;
            rr_next_s = RR_ALU;
         end
      end else if (!empty_s[0]) begin
         pop_s = 2'b01;
      end else if (!empty_s[1]) begin
         pop_s = 2'b10;
      end else begin
`ifdef REGFILE_WB_BYPASS_EN
         if (accept_s == 2'b11) begin
            if (rr_r == RR_ALU) begin
               byp_s     = 2'b01;
               rr_next_s = RR_LSU;
            end else begin
               byp_s     = 2'b10;
               rr_next_s = RR_ALU;
            end
         end else begin
            byp_s = accept_s;
         end
`else
         byp_s = 2'b00;
`endif
      end
      push_s = accept_s & ~byp_s;
      if (pop_s[0]) begin
         sel_valid_s = 1'b1;
         sel_addr_s  = q_addr_r[0][rptr_r[0][FW-1:0]];
         sel_data_s  = q_data_r[0][rptr_r[0][FW-1:0]];
      end else if (pop_s[1]) begin
         sel_valid_s = 1'b1;
         sel_addr_s  = q_addr_r[1][rptr_r[1][FW-1:0]];
         sel_data_s  = q_data_r[1][rptr_r[1][FW-1:0]];
      end else if (byp_s[0]) begin
         sel_valid_s = 1'b1;
         sel_addr_s  = in_addr_s[0];
         sel_data_s  = in_data_s[0];
      end else if (byp_s[1]) begin
         sel_valid_s = 1'b1;
         sel_addr_s  = in_addr_s[1];
         sel_data_s  = in_data_s[1];
      end else begin
         sel_valid_s = 1'b0;
      end
   end

   // Set wins over a same-edge clear; x0 can never be pending.
   always_comb begin
      pending_next_s = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         pending_next_s[i] = (bus.issue_valid && (bus.issue_addr == AW'(i))) ||
                             (pending_r[i] && !(wr_en_r && (wr_addr_r == AW'(i))));
      end
      pending_next_s[0] = 1'b0;
   end

   // FIFO storage is left unreset; only the pointers define validity.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push_s[i]) begin
            q_addr_r[i][wptr_r[i][FW-1:0]] <= in_addr_s[i];
            q_data_r[i][wptr_r[i][FW-1:0]] <= in_data_s[i];
         end
      end
   end

   // FIFO pointers, arbiter pointer, output register and scoreboard state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            wptr_r[i] <= {(FW+1){1'b0}};
            rptr_r[i] <= {(FW+1){1'b0}};
         end
         rr_r      <= RR_ALU;
         wr_en_r   <= 1'b0;
         wr_addr_r <= {AW{1'b0}};
         wr_data_r <= {WIDTH{1'b0}};
         pending_r <= {WIDTH{1'b0}};
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push_s[i]) wptr_r[i] <= wptr_r[i] + {{FW{1'b0}}, 1'b1};
            if (pop_s[i])  rptr_r[i] <= rptr_r[i] + {{FW{1'b0}}, 1'b1};
         end
         rr_r      <= rr_next_s;
         pending_r <= pending_next_s;
         if (sel_valid_s) begin
            wr_en_r   <= (sel_addr_s != {AW{1'b0}});
            wr_addr_r <= sel_addr_s;
            wr_data_r <= sel_data_s;
         end else begin
            wr_en_r   <= 1'b0;
         end
      end
   end

   assign bus.wr_en   = wr_en_r;
   assign bus.wr_addr = wr_addr_r;
   assign bus.wr_data = wr_data_r;
   assign bus.pending = pending_r;

   regfile_wb_arbiter_chk #(.WIDTH(WIDTH), .AW(AW)) u_chk (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (bus.issue_valid),
      .issue_addr  (bus.issue_addr),
      .wr_en       (wr_en_r),
      .wr_addr     (wr_addr_r),
      .pending     (pending_r)
   );
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side initiator for the register file. Merges writeback results from two producers, ALU and LSU, onto the single register-file write port (wr_en, wr_addr, wr_data).
- Buffers each producer in a small FIFO and arbitrates round-robin.
- Suppresses writes to x0.
- Keeps a pending-write scoreboard so decode can stall on RAW hazards.

Parameters:
- WIDTH, 32, data width and register count; address width AW = $clog2(WIDTH).
- FIFO_DEPTH, 2, entries per producer FIFO; power of two, >= 2.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low
- issue_valid  input  1  decode reserves issue_addr for a future write
- issue_addr  input  AW  destination register being reserved
- alu_valid  input  1  ALU result valid
- alu_ready  output  1  ALU FIFO not full
- alu_addr  input  AW  ALU destination
- alu_data  input  WIDTH  ALU result
- lsu_valid  input  1  load result valid
- lsu_ready  output  1  LSU FIFO not full
- lsu_addr  input  AW  LSU destination
- lsu_data  input  WIDTH  load data
- wr_en  output  1  register-file write enable (registered)
- wr_addr  output  AW  register-file write address (registered)
- wr_data  output  WIDTH  register-file write data (registered)
- pending  output  WIDTH  bit i set = register i has an outstanding write

Behaviour:
- Reset (rst=0 at a rising edge):
  - Both FIFOs emptied; in-flight beats are discarded.
  - Outputs: wr_en=0, wr_addr=0, wr_data=0, pending=0, alu_ready=1, lsu_ready=1 (ready reflects the flushed FIFOs).
  - Round-robin pointer resets to ALU-first.
  - Applies mid-operation with no draining.
- Handshake:
  - A beat is accepted on a rising edge where valid&&ready.
  - ready depends only on FIFO occupancy, never on valid.
  - Payload is captured at acceptance. A producer must hold payload while valid&&!ready.
- FIFOs:
  - One per producer, depth FIFO_DEPTH, read and write pointers with wrap.
  - Push and pop in the same cycle on a full FIFO is not allowed: ready=0 when full, even if a pop occurs that cycle.
  - Push and pop in the same cycle on a non-empty, non-full FIFO keeps occupancy unchanged.
- Arbiter:
  - Each cycle, pops at most one head in total.
  - If only one FIFO is non-empty, that FIFO wins.
  - If both are non-empty, the FIFO named by the round-robin pointer wins; the pointer then flips to the other FIFO.
  - The pointer flips only on contested grants.
- Output register:
  - On a pop, wr_addr and wr_data load the head entry. wr_en loads (head.addr != 0).
  - With no pop, wr_en loads 0 and wr_addr/wr_data hold their previous values.
  - wr_en is asserted for exactly one cycle per committed beat.
- Latency:
  - Uncontended beat accepted at edge k: popped at edge k+1, wr_en=1 during cycle k+1..k+2, regfile commits at edge k+2.
  - Each contention loss adds 1 cycle.
- x0:
  - A beat with addr 0 is accepted and consumes its arbitration slot, but never asserts wr_en.
  - issue to addr 0 is ignored.
- Scoreboard:
  - pending[issue_addr] is set at an edge with issue_valid=1 (addr != 0).
  - pending[wr_addr] is cleared at the edge ending a cycle with wr_en=1.
  - Same register set and cleared on the same edge: set wins.
  - pending[0] is always 0.
  - Two outstanding writes to the same register are illegal (checked by assertion); ordering between ALU and LSU for one register is not guaranteed.
- Throughput: at most one regfile write per cycle. Sustained input above 1 beat/cycle backpressures through ready.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - A beat accepted while its FIFO is empty and the arbiter has no other head to pop bypasses the FIFO and loads the output register on its acceptance edge.
  - wr_en=1 in cycle k..k+1; latency is 1 cycle shorter.
  - If both producers present into empty FIFOs in the same cycle, the round-robin winner bypasses and the other is enqueued.
- Undefined: every beat goes through its FIFO; latency as stated above.

Test Plan:
1. Reset flush: fill ALU FIFO with 2 beats, drive rst=0 for 1 cycle -> wr_en stays 0; pending=0; alu_ready=1 next cycle; no write of the flushed beats ever appears.
2. Single ALU beat: issue addr 5, then alu addr=5 data=0xDEADBEEF -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF exactly one cycle after acceptance+1 (bypass: acceptance cycle+1); pending[5] rises then falls after that cycle.
3. Contention: ALU and LSU each push 3 beats back-to-back (addrs 1..3 and 9..11) -> writes alternate 1,9,2,10,3,11; ready drops to 0 when FIFO holds 2; no beat lost or duplicated.
4. x0 drop: alu addr=0 data=0x1234 -> accepted, wr_en never 1 for it; pending[0]=0 throughout; next beat addr=7 commits normally.
5. Scoreboard collision: pending[4] set; same edge as wr_en commit of addr 4, issue_valid addr 4 -> pending[4] remains 1.
6. Backpressure hold: LSU FIFO full, lsu_valid held with addr=12 data=0xA5A5A5A5 -> accepted only after a pop; committed value is exactly 0xA5A5A5A5 to register 12.
